// File: rtl/aes_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_stream_pkg
// Description : Shared widths, cipher-direction constants and FSM state codes
//               for the AES stream controller.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_stream_pkg;

    localparam int AES_BLOCK_W = 128;

    // Direction encoding matches the legacy AES core defines.
    localparam logic ENCRYPT = 1'b1;
    localparam logic DECRYPT = 1'b0;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE  = 3'd0;
    localparam state_t c_ST_ISSUE = 3'd1;
    localparam state_t c_ST_WAIT  = 3'd2;
    localparam state_t c_ST_HOLD  = 3'd3;
    localparam state_t c_ST_ERROR = 3'd4;

endpackage
`default_nettype wire

// File: rtl/aes_ctr_counter.sv
`default_nettype none
// ============================================================================
// Module      : aes_ctr_counter
// Description : Loadable block counter for CTR mode, wraps modulo 2^WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_ctr_counter
    import aes_stream_pkg::*;
#(
    parameter int WIDTH = AES_BLOCK_W
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] load_val_in,
    input  logic             inc_in,
    output logic [WIDTH-1:0] count_out
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_count <= '0;
        end else if (load_in) begin
            r_count <= load_val_in;
        end else if (inc_in) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count_out = r_count;

endmodule
`default_nettype wire

// File: rtl/aes_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_stream_ctrl
// Description : Valid/ready block streamer around an iterative AES core with
//               timeout detection. Define AES_STREAM_CTR_EN for CTR mode.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_stream_ctrl
    import aes_stream_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic [AES_BLOCK_W-1:0] key_in,
    input  logic                   mode_in,
    input  logic [AES_BLOCK_W-1:0] s_data_in,
    input  logic                   s_valid_in,
    output logic                   s_ready_out,
    output logic [AES_BLOCK_W-1:0] m_data_out,
    output logic                   m_valid_out,
    input  logic                   m_ready_in,
    output logic                   core_init_out,
    output logic                   core_mode_out,
    output logic [AES_BLOCK_W-1:0] core_data_out,
    output logic [AES_BLOCK_W-1:0] core_key_out,
    input  logic [AES_BLOCK_W-1:0] core_data_in,
    input  logic                   core_valid_in,
    output logic                   busy_out,
    output logic                   timeout_out
`ifdef AES_STREAM_CTR_EN
    ,
    input  logic [AES_BLOCK_W-1:0] iv_in,
    input  logic                   iv_load_in
`endif
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                 r_state;
    logic [c_CNT_W-1:0]     r_wait_cnt;
    logic [AES_BLOCK_W-1:0] r_block;
    logic [AES_BLOCK_W-1:0] r_key;
    logic [AES_BLOCK_W-1:0] r_result;
    logic                   r_mode;
    logic                   r_timeout;
    logic                   w_accept;
    logic [AES_BLOCK_W-1:0] w_result;

    // Gating with reset keeps ready low while reset is held, not just after.
    assign s_ready_out = rst_n_in &
                         ((r_state == c_ST_IDLE) || ((r_state == c_ST_HOLD) && m_ready_in));
    assign w_accept    = s_valid_in & s_ready_out;

`ifdef AES_STREAM_CTR_EN
    logic [AES_BLOCK_W-1:0] w_ctr;
    logic [AES_BLOCK_W-1:0] r_ctr_snap;

    aes_ctr_counter #(
        .WIDTH       (AES_BLOCK_W)
    ) u_ctr (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .load_in     (iv_load_in && (r_state == c_ST_IDLE)),
        .load_val_in (iv_in),
        .inc_in      (r_state == c_ST_ISSUE),
        .count_out   (w_ctr)
    );

    // Snapshot keeps the core input stable while the counter advances in ISSUE.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_ctr_snap <= '0;
        end else if (w_accept) begin
            r_ctr_snap <= w_ctr;
        end
    end

    assign w_result      = core_data_in ^ r_block;
    assign core_data_out = r_ctr_snap;
    assign core_mode_out = ENCRYPT;
`else
    assign w_result      = core_data_in;
    assign core_data_out = r_block;
    assign core_mode_out = r_mode;
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state    <= c_ST_IDLE;
            r_wait_cnt <= '0;
            r_block    <= '0;
            r_key      <= '0;
            r_mode     <= DECRYPT;
            r_result   <= '0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    if (core_valid_in) begin
                        r_result <= w_result;
                        r_state  <= c_ST_HOLD;
                    end else if (r_wait_cnt == c_CNT_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= c_ST_ERROR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
                    end
                end
                c_ST_HOLD: begin
                    if (m_ready_in) begin
                        r_state <= w_accept ? c_ST_ISSUE : c_ST_IDLE;
                    end
                end
                c_ST_ERROR: begin
                    r_state <= c_ST_ERROR;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase

            if (w_accept) begin
                r_block <= s_data_in;
                r_key   <= key_in;
                r_mode  <= mode_in;
            end
        end
    end

    assign m_valid_out   = (r_state == c_ST_HOLD);
    assign m_data_out    = r_result;
    assign core_init_out = (r_state == c_ST_ISSUE);
    assign core_key_out  = r_key;
    assign busy_out      = (r_state != c_ST_IDLE);
    assign timeout_out   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_aes_stream_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_aes_stream_ctrl
// Description : Scoreboard bench for aes_stream_ctrl with a behavioural AES
//               core stub. Honours AES_STREAM_CTR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_stream_ctrl;
    import aes_stream_pkg::*;

    localparam int           c_TIMEOUT = 16;
    localparam logic [127:0] c_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic [127:0] key_in;
    logic         mode_in;
    logic [127:0] s_data_in;
    logic         s_valid_in;
    wire          s_ready_out;
    wire  [127:0] m_data_out;
    wire          m_valid_out;
    logic         m_ready_in;
    wire          core_init_out;
    wire          core_mode_out;
    wire  [127:0] core_data_out;
    wire  [127:0] core_key_out;
    wire  [127:0] core_data_in;
    wire          core_valid_in;
    wire          busy_out;
    wire          timeout_out;
`ifdef AES_STREAM_CTR_EN
    logic [127:0] iv_in;
    logic         iv_load_in;
    logic [127:0] ctr_model;
`endif

    logic         stub_valid;
    logic         spur_valid;
    logic [127:0] stub_data;
    bit           core_en = 1'b1;
    int           core_lat = 2;

    int           n_checks = 0;
    int           n_fail = 0;
    int           init_count = 0;
    logic [127:0] exp_q[$];

    assign core_valid_in = stub_valid | spur_valid;
    assign core_data_in  = stub_data;

    always #5 clk_in = ~clk_in;

    aes_stream_ctrl #(
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .key_in        (key_in),
        .mode_in       (mode_in),
        .s_data_in     (s_data_in),
        .s_valid_in    (s_valid_in),
        .s_ready_out   (s_ready_out),
        .m_data_out    (m_data_out),
        .m_valid_out   (m_valid_out),
        .m_ready_in    (m_ready_in),
        .core_init_out (core_init_out),
        .core_mode_out (core_mode_out),
        .core_data_out (core_data_out),
        .core_key_out  (core_key_out),
        .core_data_in  (core_data_in),
        .core_valid_in (core_valid_in),
        .busy_out      (busy_out),
        .timeout_out   (timeout_out)
`ifdef AES_STREAM_CTR_EN
        ,
        .iv_in         (iv_in),
        .iv_load_in    (iv_load_in)
`endif
    );

    // Stand-in cipher for inputs outside the FIPS-197 vector.
    function automatic logic [127:0] fake_cipher(input logic [127:0] k, input logic [127:0] d,
                                                 input logic m);
        return {d[63:0], d[127:64]} ^ k ^ (m ? {4{32'ha5a5_5a5a}} : {4{32'h3c3c_c3c3}});
    endfunction

    function automatic logic [127:0] core_model(input logic [127:0] k, input logic [127:0] d,
                                                input logic m);
        if (k == c_KEY && m == ENCRYPT && d == c_PT) return c_CT;
        if (k == c_KEY && m == DECRYPT && d == c_CT) return c_PT;
        return fake_cipher(k, d, m);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // AES core stub: answers core_lat cycles after an init pulse.
    initial begin
        logic [127:0] k;
        logic [127:0] d;
        logic         m;
        stub_valid = 1'b0;
        stub_data  = '0;
        forever begin
            @(negedge clk_in);
            if (core_init_out && core_en) begin
                k = core_key_out;
                d = core_data_out;
                m = core_mode_out;
                repeat (core_lat) @(negedge clk_in);
                stub_data  = core_model(k, d, m);
                stub_valid = 1'b1;
                @(negedge clk_in);
                stub_valid = 1'b0;
                stub_data  = '0;
            end
        end
    end

    // Output monitor: pops the scoreboard on every output handshake.
    initial begin
        forever begin
            @(negedge clk_in);
            if (core_init_out) init_count++;
            if (m_valid_out && m_ready_in) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h expected no output", m_data_out);
                end else begin
                    check("scoreboard", m_data_out, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [127:0] d, input logic [127:0] k, input logic m,
                        input logic mr, input bit expect_out);
        int           t;
        logic [127:0] e;
        @(posedge clk_in); #1;
        s_data_in  = d;
        key_in     = k;
        mode_in    = m;
        m_ready_in = mr;
        s_valid_in = 1'b1;
        t = 0;
        do begin
            @(negedge clk_in);
            t++;
        end while (!s_ready_out && t < 50);
        check("accept_ready", 128'(s_ready_out), 128'(1));
`ifdef AES_STREAM_CTR_EN
        e = core_model(k, ctr_model, ENCRYPT) ^ d;
`else
        e = core_model(k, d, m);
`endif
        if (expect_out) exp_q.push_back(e);
        @(posedge clk_in); #1;
        s_valid_in = 1'b0;
        s_data_in  = ~d;
        key_in     = ~k;
        mode_in    = ~m;
        @(negedge clk_in);
        check("init_after_accept", 128'(core_init_out), 128'(1));
        check("core_key_latched", core_key_out, k);
`ifdef AES_STREAM_CTR_EN
        check("core_data_ctr", core_data_out, ctr_model);
        check("core_mode_ctr", 128'(core_mode_out), 128'(ENCRYPT));
        ctr_model = ctr_model + 128'd1;
`else
        check("core_data_latched", core_data_out, d);
        check("core_mode_latched", 128'(core_mode_out), 128'(m));
`endif
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk_in);
            t++;
        end
        check("drain", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic pulse_reset();
        @(posedge clk_in); #1;
        rst_n_in = 1'b0;
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
`ifdef AES_STREAM_CTR_EN
        ctr_model = '0;
`endif
    endtask

    initial begin
        int           i0;
        int           n;
        logic [127:0] held;
        rst_n_in   = 1'b0;
        key_in     = '0;
        mode_in    = 1'b0;
        s_data_in  = '0;
        s_valid_in = 1'b0;
        m_ready_in = 1'b1;
        spur_valid = 1'b0;
`ifdef AES_STREAM_CTR_EN
        iv_in      = '1;
        iv_load_in = 1'b0;
        ctr_model  = '1;
`endif
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_s_ready", 128'(s_ready_out), 128'(0));
        check("rst_m_valid", 128'(m_valid_out), 128'(0));
        check("rst_m_data", m_data_out, 128'(0));
        check("rst_core_init", 128'(core_init_out), 128'(0));
        check("rst_core_data", core_data_out, 128'(0));
        check("rst_core_key", core_key_out, 128'(0));
        check("rst_core_mode", 128'(core_mode_out), 128'(0));
        check("rst_busy", 128'(busy_out), 128'(0));
        check("rst_timeout", 128'(timeout_out), 128'(0));

        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
`ifdef AES_STREAM_CTR_EN
        iv_load_in = 1'b1;
        @(posedge clk_in); #1;
        iv_load_in = 1'b0;
`endif
        @(negedge clk_in);
        check("idle_s_ready", 128'(s_ready_out), 128'(1));
        check("idle_busy", 128'(busy_out), 128'(0));

        // FIPS-197 encrypt with latency check.
        i0 = init_count;
        send(c_PT, c_KEY, ENCRYPT, 1'b1, 1'b1);
        repeat (2) begin
            @(negedge clk_in);
            check("lat_m_valid_low", 128'(m_valid_out), 128'(0));
        end
        @(negedge clk_in);
        check("lat_m_valid_high", 128'(m_valid_out), 128'(1));
        drain();
        check("enc_init_pulses", 128'(init_count - i0), 128'(1));

        i0 = init_count;
        send(c_CT, c_KEY, DECRYPT, 1'b1, 1'b1);
        drain();
        check("dec_init_pulses", 128'(init_count - i0), 128'(1));

        send(128'hdeadbeef_01234567_89abcdef_feedface, 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0,
             ENCRYPT, 1'b1, 1'b1);
        send(128'h11111111_22222222_33333333_44444444, 128'hffffffff_00000000_ffffffff_00000000,
             DECRYPT, 1'b1, 1'b1);
        drain();

        // Stray core_valid_in while idle.
        @(posedge clk_in); #1;
        spur_valid = 1'b1;
        @(posedge clk_in); #1;
        spur_valid = 1'b0;
        @(negedge clk_in);
        check("spur_idle_m_valid", 128'(m_valid_out), 128'(0));
        check("spur_idle_busy", 128'(busy_out), 128'(0));

        // Backpressure then back-to-back accept.
        i0 = init_count;
        send(128'hcafebabe_cafebabe_00000000_12345678, c_KEY, ENCRYPT, 1'b0, 1'b1);
        n = 0;
        while (!m_valid_out && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        check("bp_valid_seen", 128'(m_valid_out), 128'(1));
        held = exp_q[0];
        repeat (10) begin
            @(negedge clk_in);
            check("bp_m_valid", 128'(m_valid_out), 128'(1));
            check("bp_m_data", m_data_out, held);
            check("bp_s_ready", 128'(s_ready_out), 128'(0));
        end
        check("bp_init_pulses", 128'(init_count - i0), 128'(1));
        send(128'h0badf00d_0badf00d_0badf00d_0badf00d, c_KEY, DECRYPT, 1'b1, 1'b1);
        drain();

        // Core never answers.
        core_en = 1'b0;
        send(c_PT, c_KEY, ENCRYPT, 1'b1, 1'b0);
        n = 0;
        while (!timeout_out && n < 40) begin
            @(negedge clk_in);
            if (!timeout_out) n++;
        end
        check("timeout_wait_cycles", 128'(n), 128'(c_TIMEOUT));
        @(posedge clk_in); #1;
        s_valid_in = 1'b1;
        spur_valid = 1'b1;
        repeat (5) begin
            @(negedge clk_in);
            check("err_timeout", 128'(timeout_out), 128'(1));
            check("err_s_ready", 128'(s_ready_out), 128'(0));
            check("err_m_valid", 128'(m_valid_out), 128'(0));
            check("err_busy", 128'(busy_out), 128'(1));
        end
        @(posedge clk_in); #1;
        s_valid_in = 1'b0;
        spur_valid = 1'b0;
        core_en    = 1'b1;
        pulse_reset();
        @(negedge clk_in);
        check("rst_clears_timeout", 128'(timeout_out), 128'(0));
        check("rst_clears_busy", 128'(busy_out), 128'(0));

        // Reset mid-WAIT followed by a late core response.
        core_lat = 6;
        send(c_PT, c_KEY, ENCRYPT, 1'b1, 1'b0);
        repeat (2) @(negedge clk_in);
        pulse_reset();
        repeat (10) begin
            @(negedge clk_in);
            check("late_valid_m_valid", 128'(m_valid_out), 128'(0));
            check("late_valid_idle", 128'(busy_out), 128'(0));
        end
        core_lat = 2;
        send(c_CT, c_KEY, DECRYPT, 1'b1, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
